saturate_rgb: RTL and testbench
===============================

Name: saturate_rgb

Overview:
- Registered three-channel clamp stage placed after the contrast multiply in the video pipeline.
- Takes wide unsigned per-channel products (IN_W bits, already scaled) and clamps each to OUT_W-bit pixel range.
- Flags channels that clipped and counts clipped pixels per frame for auto-contrast/statistics logic.

Parameters:
- IN_W, 10, width of each input channel value.
- OUT_W, 8, width of each output channel; must satisfy OUT_W < IN_W.
- CNT_W, 20, width of clipped-pixel counters.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  pixel on in_r/in_g/in_b is valid this cycle.
- frame_start  input  1  first pixel of a new frame (qualified by nothing; may occur without in_valid).
- in_r  input  IN_W  red channel value.
- in_g  input  IN_W  green channel value.
- in_b  input  IN_W  blue channel value.
- out_r  output  OUT_W  clamped red.
- out_g  output  OUT_W  clamped green.
- out_b  output  OUT_W  clamped blue.
- out_valid  output  1  registered copy of in_valid.
- sat_r  output  1  red clipped on the pixel currently on outputs.
- sat_g  output  1  green clipped.
- sat_b  output  1  blue clipped.
- sat_count  output  CNT_W  number of pixels (any channel clipped) in the previous completed frame.

Behaviour:
- Reset: out_r/g/b=0, out_valid=0, sat_r/g/b=0, sat_count=0, internal running counter=0. Reset overrides all other inputs in the same cycle.
- Clamp per channel (default unsigned): if in > 2^OUT_W-1 then out = 2^OUT_W-1 (all ones), sat_x=1; else out = in[OUT_W-1:0], sat_x=0. Example IN_W=10/OUT_W=8: 255->255, 256->255, 1023->255, 0->0.
- Latency: exactly 1 cycle, input sampled at edge N appears on outputs after edge N. out_valid follows in_valid with same latency.
- When in_valid=0: data/flag registers still load (outputs follow inputs), out_valid=0; flags are only meaningful with out_valid=1.
- No backpressure; stage accepts every cycle.
- Running counter: increments by 1 on each cycle with in_valid=1 and any channel clipped; saturates at 2^CNT_W-1 (no wrap).
- frame_start=1: sat_count <= running counter value before this cycle; running counter restarts at (in_valid && any clip ? 1 : 0), i.e. the pixel coincident with frame_start belongs to the new frame.
- sat_count holds between frame_start pulses.
- Back-to-back frame_start: each publishes the count accumulated since the previous one (possibly 0).

Optional Feature:
- Macro SATURATE_RGB_SIGNED_EN.
- Defined: inputs are two's complement IN_W-bit; negative values clamp to 0 with sat_x=1; values > 2^OUT_W-1 clamp to all ones with sat_x=1; otherwise pass low OUT_W bits. Example 10-bit 0x3FF (-1)->0, sat=1.
- Undefined: unsigned behaviour above; 0x3FF->255, sat=1.

Test Plan:
- Reset: hold rst=1 two cycles with in=1023, in_valid=1 -> all outputs 0, out_valid=0, sat_count=0.
- Pass-through: in_r=0, in_g=128, in_b=255, in_valid=1 -> next cycle out=0/128/255, sat=000, out_valid=1.
- Boundary: in_r=256, in_g=255, in_b=1023 -> out=255/255/255, sat_r=1, sat_g=0, sat_b=1.
- Counting: frame_start, then 5 valid pixels of which 3 clip (one with in_valid=0 and 1023 not counted), then frame_start -> sat_count=3 after second frame_start edge.
- Coincident: frame_start with in_valid=1 and in_r=300 -> published count excludes it; next frame_start publishes >=1.
- Signed build (SATURATE_RGB_SIGNED_EN): in_r=0x3FF, in_g=0x200, in_b=0x07F -> out=0/0/127, sat=1/1/0.

Source files
------------

// File: rtl/saturate_rgb.sv
// saturate_rgb: three-channel clamp of wide contrast products to pixel range, with per-frame clip count.
// Latency: 1 cycle from in_* to out_*/sat_*/out_valid; sat_count updates on the edge that samples frame_start.
// Backpressure: none; the stage accepts a pixel every cycle.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_r/g/b  input pixel (IN_W bits per channel) and its qualifier
//   frame_start         first cycle of a new frame; independent of in_valid
//   out_r/g/b           clamped channels (OUT_W bits), registered
//   out_valid           registered in_valid
//   sat_r/g/b           per-channel clip flags for the pixel on the outputs
//   sat_count           clipped-pixel count of the previous completed frame
//
// Build option: define SATURATE_RGB_SIGNED_EN to treat inputs as two's complement
// (negative values clamp to 0 and flag as clipped). Default build is unsigned.

module saturate_rgb #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             frame_start,
    input  logic [IN_W-1:0]  in_r,
    input  logic [IN_W-1:0]  in_g,
    input  logic [IN_W-1:0]  in_b,
    output logic [OUT_W-1:0] out_r,
    output logic [OUT_W-1:0] out_g,
    output logic [OUT_W-1:0] out_b,
    output logic             out_valid,
    output logic             sat_r,
    output logic             sat_g,
    output logic             sat_b,
    output logic [CNT_W-1:0] sat_count
);

    // Largest representable output value, expressed at input width for comparison.
    localparam logic [IN_W-1:0]  MAX_IN  = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [OUT_W-1:0] MAX_OUT = {OUT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {clipped, clamped_value}.
    function automatic logic [OUT_W:0] clamp(input logic [IN_W-1:0] v);
        logic [OUT_W:0] res;
`ifdef SATURATE_RGB_SIGNED_EN
        if (v[IN_W-1]) begin
            res = {1'b1, {OUT_W{1'b0}}};
        end else if (v > MAX_IN) begin
            res = {1'b1, MAX_OUT};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
`else
        if (v > MAX_IN) begin
            res = {1'b1, MAX_OUT};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
`endif
        return res;
    endfunction

    logic [OUT_W-1:0] out_r_d, out_r_q;
    logic [OUT_W-1:0] out_g_d, out_g_q;
    logic [OUT_W-1:0] out_b_d, out_b_q;
    logic             sat_r_d, sat_r_q;
    logic             sat_g_d, sat_g_q;
    logic             sat_b_d, sat_b_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] run_cnt_d, run_cnt_q;
    logic [CNT_W-1:0] sat_count_d, sat_count_q;
    logic             pix_clip;
    logic [CNT_W-1:0] run_cnt_inc;

    always_comb begin
        {sat_r_d, out_r_d} = clamp(in_r);
        {sat_g_d, out_g_d} = clamp(in_g);
        {sat_b_d, out_b_d} = clamp(in_b);
        out_valid_d        = in_valid;

        // Only qualified pixels contribute to the frame statistic.
        pix_clip    = in_valid & (sat_r_d | sat_g_d | sat_b_d);
        run_cnt_inc = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;

        sat_count_d = sat_count_q;
        run_cnt_d   = pix_clip ? run_cnt_inc : run_cnt_q;
        if (frame_start) begin
            // Pixel coincident with frame_start belongs to the new frame.
            sat_count_d = run_cnt_q;
            run_cnt_d   = pix_clip ? CNT_ONE : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            sat_r_q     <= 1'b0;
            sat_g_q     <= 1'b0;
            sat_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            run_cnt_q   <= '0;
            sat_count_q <= '0;
        end else begin
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            sat_r_q     <= sat_r_d;
            sat_g_q     <= sat_g_d;
            sat_b_q     <= sat_b_d;
            out_valid_q <= out_valid_d;
            run_cnt_q   <= run_cnt_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;
    assign sat_r     = sat_r_q;
    assign sat_g     = sat_g_q;
    assign sat_b     = sat_b_q;
    assign out_valid = out_valid_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_saturate_rgb.sv
// Testbench for saturate_rgb: directed vectors with hand-computed expectations.
// A second instance with a 2-bit counter exercises counter saturation.
// Build with SATURATE_RGB_SIGNED_EN defined to exercise the signed clamp.

module tb_saturate_rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        frame_start;
    logic [9:0]  in_r, in_g, in_b;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_valid, sat_r, sat_g, sat_b;
    logic [19:0] sat_count;

    logic [7:0]  s_out_r, s_out_g, s_out_b;
    logic        s_out_valid, s_sat_r, s_sat_g, s_sat_b;
    logic [1:0]  s_sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    saturate_rgb #(.IN_W(10), .OUT_W(8), .CNT_W(20)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_valid(out_valid),
        .sat_r(sat_r), .sat_g(sat_g), .sat_b(sat_b), .sat_count(sat_count)
    );

    saturate_rgb #(.IN_W(10), .OUT_W(8), .CNT_W(2)) u_dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_r(s_out_r), .out_g(s_out_g), .out_b(s_out_b), .out_valid(s_out_valid),
        .sat_r(s_sat_r), .sat_g(s_sat_g), .sat_b(s_sat_b), .sat_count(s_sat_count)
    );

    task automatic drive(input logic v, input logic fs,
                         input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        in_valid    = v;
        frame_start = fs;
        in_r        = r;
        in_g        = g;
        in_b        = b;
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 10'd1023, 10'd1023, 10'd1023);
        step();
        step();
        checks++;
        if ({out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid} !== 28'd0) begin
            errors++;
            $display("FAIL reset_pix actual=%h/%h/%h sat=%b%b%b vld=%b required=0/0/0 sat=000 vld=0",
                     out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid);
        end
        checks++;
        if (sat_count !== 20'd0) begin
            errors++;
            $display("FAIL reset_count actual=%0d required=0", sat_count);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        step();
    endtask

    task automatic test_pass_through();
        drive(1'b1, 1'b0, 10'd0, 10'd128, 10'd255);
        step();
        checks++;
        if ({out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid} !== {8'd0, 8'd128, 8'd255, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL pass_through actual=%0d/%0d/%0d sat=%b%b%b vld=%b required=0/128/255 sat=000 vld=1",
                     out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] exp_b;
        drive(1'b1, 1'b0, 10'd256, 10'd255, 10'd1023);
`ifdef SATURATE_RGB_SIGNED_EN
        exp_b = 8'd0;     // 0x3FF is -1
`else
        exp_b = 8'd255;
`endif
        step();
        checks++;
        if ({out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid} !== {8'd255, 8'd255, exp_b, 3'b101, 1'b1}) begin
            errors++;
            $display("FAIL boundary actual=%0d/%0d/%0d sat=%b%b%b vld=%b required=255/255/%0d sat=101 vld=1",
                     out_r, out_g, out_b, sat_r, sat_g, sat_b, out_valid, exp_b);
        end
    endtask

    task automatic test_counting();
        // Publishes the boundary pixel counted since reset.
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd1) begin
            errors++;
            $display("FAIL count_first_frame actual=%0d required=1", sat_count);
        end
        drive(1'b1, 1'b0, 10'd1023, 10'd0,   10'd0);   step();
        drive(1'b1, 1'b0, 10'd10,   10'd20,  10'd30);  step();
        drive(1'b1, 1'b0, 10'd0,    10'd300, 10'd0);   step();
        drive(1'b1, 1'b0, 10'd255,  10'd255, 10'd255); step();
        drive(1'b1, 1'b0, 10'd512,  10'd512, 10'd512); step();
        drive(1'b0, 1'b0, 10'd1023, 10'd1023, 10'd1023);
        step();
        checks++;
        if ({out_valid, sat_r, sat_g, sat_b} !== 4'b0111) begin
            errors++;
            $display("FAIL invalid_pixel actual vld=%b sat=%b%b%b required vld=0 sat=111",
                     out_valid, sat_r, sat_g, sat_b);
        end
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd3) begin
            errors++;
            $display("FAIL count_frame actual=%0d required=3", sat_count);
        end
        drive(1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        step();
        step();
        checks++;
        if (sat_count !== 20'd3) begin
            errors++;
            $display("FAIL count_hold actual=%0d required=3", sat_count);
        end
    endtask

    task automatic test_coincident();
        drive(1'b1, 1'b1, 10'd300, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd0) begin
            errors++;
            $display("FAIL coincident_excl actual=%0d required=0", sat_count);
        end
        checks++;
        if ({out_r, sat_r, out_valid} !== {8'd255, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL coincident_pix actual=%0d sat_r=%b vld=%b required=255 sat_r=1 vld=1",
                     out_r, sat_r, out_valid);
        end
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd1) begin
            errors++;
            $display("FAIL coincident_next actual=%0d required=1", sat_count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd0) begin
            errors++;
            $display("FAIL back_to_back actual=%0d required=0", sat_count);
        end
    endtask

    task automatic test_count_saturate();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 10'd400, 10'd0, 10'd0);
            step();
        end
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd6) begin
            errors++;
            $display("FAIL count_six actual=%0d required=6", sat_count);
        end
        checks++;
        if (s_sat_count !== 2'd3) begin
            errors++;
            $display("FAIL count_sat_small actual=%0d required=3", s_sat_count);
        end
    endtask

    task automatic test_reset_counter();
        drive(1'b1, 1'b0, 10'd999, 10'd0, 10'd0);
        step();
        step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 10'd999, 10'd0, 10'd0);
        step();
        rst = 1'b0;
        checks++;
        if ({sat_count, out_valid, sat_r} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid actual cnt=%0d vld=%b sat_r=%b required 0/0/0",
                     sat_count, out_valid, sat_r);
        end
        drive(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        step();
        checks++;
        if (sat_count !== 20'd0) begin
            errors++;
            $display("FAIL reset_run_cnt actual=%0d required=0", sat_count);
        end
    endtask

    task automatic test_sign_mode();
        drive(1'b1, 1'b0, 10'h3FF, 10'h200, 10'h07F);
        step();
`ifdef SATURATE_RGB_SIGNED_EN
        checks++;
        if ({out_r, out_g, out_b, sat_r, sat_g, sat_b} !== {8'd0, 8'd0, 8'd127, 3'b110}) begin
            errors++;
            $display("FAIL signed_clamp actual=%0d/%0d/%0d sat=%b%b%b required=0/0/127 sat=110",
                     out_r, out_g, out_b, sat_r, sat_g, sat_b);
        end
`else
        checks++;
        if ({out_r, out_g, out_b, sat_r, sat_g, sat_b} !== {8'd255, 8'd255, 8'd127, 3'b110}) begin
            errors++;
            $display("FAIL unsigned_clamp actual=%0d/%0d/%0d sat=%b%b%b required=255/255/127 sat=110",
                     out_r, out_g, out_b, sat_r, sat_g, sat_b);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        test_reset();
        test_pass_through();
        test_boundary();
        test_counting();
        test_coincident();
        test_back_to_back();
        test_count_saturate();
        test_sign_mode();
        test_reset_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
